// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch realignment buffer.
package fetch_pkg;
    localparam logic [1:0] OPC_FULL = 2'b11;
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0080;
    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } entry_t;
endpackage

// File: rtl/instr_realign_fifo.sv
// instr_realign_fifo: word queue that realigns the halfword stream so [15:0] starts each instruction.
// Define INSTR_FIFO_BYPASS_EN to expose the arriving word to the output in its arrival cycle.
module instr_realign_fifo
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 3,
    parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o
);
    localparam int CW = $clog2(DEPTH + 1);
`ifdef INSTR_FIFO_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif
    entry_t          entries [DEPTH];
    entry_t          entries_nxt [DEPTH];
    entry_t          ext [DEPTH+1];
    entry_t          in_word, e0;
    logic            e1_err;
    logic [15:0]     e1_lo, h;
    logic [CW-1:0]   count, count_nxt;
    logic [31:0]     addr_q, addr_nxt;
    logic            arriving, has1, has2, unal, is32, fire, pop, push;
    assign in_word  = '{err: in_err_i, data: in_rdata_i};
    assign arriving = in_valid_i && !clear_i;
    // Absent entries read as zero so a lone erroring first half yields a clean upper half.
    always_comb begin
        e0 = '0;
        e1_err = 1'b0;
        e1_lo = '0;
        has1 = count >= CW'(1);
        has2 = count >= CW'(2);
        if (has1) e0 = entries[0];
        else if (BYPASS && arriving) begin
            e0 = in_word;
            has1 = 1'b1;
        end
        if (has2) {e1_err, e1_lo} = {entries[1].err, entries[1].data[15:0]};
        else if (BYPASS && arriving && count == CW'(1)) begin
            {e1_err, e1_lo} = {in_err_i, in_rdata_i[15:0]};
            has2 = 1'b1;
        end
    end
    assign unal        = addr_q[1];
    assign h           = unal ? e0.data[31:16] : e0.data[15:0];
    assign is32        = h[1:0] == OPC_FULL;
    assign out_valid_o = has1 && (!unal || !is32 || has2 || e0.err);
    assign out_rdata_o = !out_valid_o ? '0 : !is32 ? {16'b0, h} : {unal ? e1_lo : e0.data[31:16], h};
    assign out_err_o   = out_valid_o && (e0.err || (unal && is32 && e1_err));
    assign out_addr_o  = addr_q;
    assign busy_o      = count >= CW'(DEPTH - 1);
    assign fire        = out_valid_o && out_ready_i && !clear_i;
    assign addr_nxt    = addr_q + (is32 ? 32'd4 : 32'd2);
    assign pop         = fire && (!addr_nxt[1] || (unal && is32));
    assign push        = arriving && (count < CW'(DEPTH) || pop);
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ext[i] = (push && count == CW'(i)) ? in_word : entries[i];
        ext[DEPTH] = in_word;
        for (int i = 0; i < DEPTH; i++) entries_nxt[i] = pop ? ext[i+1] : ext[i];
        count_nxt = count + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count   <= '0;
            addr_q  <= BOOT_ADDR;
            entries <= '{default: '0};
        end else if (clear_i) begin
            count  <= '0;
            addr_q <= clear_addr_i & ~32'd1;
        end else begin
            count   <= count_nxt;
            addr_q  <= fire ? addr_nxt : addr_q;
            entries <= entries_nxt;
        end
    end
endmodule

// File: tb/tb_instr_realign_fifo.sv
// tb_instr_realign_fifo: directed stimulus checked every cycle against a halfword-stream model.
module tb_instr_realign_fifo;
    localparam int DEPTH = 3;
    logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, in_err = 1'b0, out_ready = 1'b0;
    logic [31:0] clear_addr = '0, in_rdata = '0;
    logic        busy, out_valid, out_err;
    logic [31:0] out_rdata, out_addr;
    int          errors = 0, checks = 0, cyc = 0;
    logic [31:0] m_data[$];
    logic        m_err[$];
    logic [31:0] m_addr = 32'h80;
    logic [31:0] hs_addr[$], hs_data[$];
    logic [31:0] tbl [10] = '{32'h0001_4501, 32'h0513_0093, 32'h8082_0413, 32'h4505_c002,
                              32'h0000_0001, 32'h00a5_0533, 32'hffff_4581, 32'h1234_0003,
                              32'h4401_8082, 32'h0000_0013};

    instr_realign_fifo dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .clear_addr_i(clear_addr),
        .in_valid_i(in_valid), .in_rdata_i(in_rdata), .in_err_i(in_err), .busy_o(busy),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_rdata_o(out_rdata),
        .out_addr_o(out_addr), .out_err_o(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic e, input logic rdy,
                         input logic clr = 1'b0, input logic [31:0] ca = '0);
        @(posedge clk); #1;
        in_valid = v; in_rdata = d; in_err = e; out_ready = rdy; clear = clr; clear_addr = ca;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    task automatic check_hs(input string nm, input int k, input logic [31:0] ea, input logic [31:0] ed);
        if (k < hs_addr.size()) begin
            chk({nm, "_addr"}, hs_addr[k], ea);
            chk({nm, "_data"}, hs_data[k], ed);
        end else chk({nm, "_present"}, 32'(hs_addr.size()), 32'(k + 1));
    endtask

    // Model: the queue is a halfword stream starting at m_addr; an instruction needs 1 or 2 halfwords.
    initial begin
        logic [31:0] wd [DEPTH+1];
        logic        we [DEPTH+1];
        logic [15:0] lo, hi;
        logic        is32, ev, ee;
        int          n, off, halves, need, idx, pops;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_data.delete(); m_err.delete(); m_addr = 32'h80;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_rdata", out_rdata, 32'd0);
                chk("rst_addr", out_addr, 32'h80);
                chk("rst_err", 32'(out_err), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
            end else begin
                n = m_data.size();
                for (int i = 0; i < n; i++) begin wd[i] = m_data[i]; we[i] = m_err[i]; end
`ifdef INSTR_FIFO_BYPASS_EN
                if (in_valid && !clear && n < DEPTH) begin wd[n] = in_rdata; we[n] = in_err; n++; end
`endif
                off    = int'(m_addr[1]);
                lo     = n == 0 ? 16'h0 : off == 1 ? wd[0][31:16] : wd[0][15:0];
                is32   = lo[1:0] == 2'b11;
                halves = is32 ? 2 : 1;
                need   = (off + halves + 1) / 2;
                ev     = n >= need || (n >= 1 && we[0]);
                idx    = off + 1;
                hi     = idx / 2 >= n ? 16'h0 : idx % 2 == 1 ? wd[idx/2][31:16] : wd[idx/2][15:0];
                ee     = 1'b0;
                for (int j = 0; j < need && j < n; j++) ee |= we[j];
                chk("valid", 32'(out_valid), 32'(ev));
                chk("rdata", out_rdata, !ev ? 32'd0 : is32 ? {hi, lo} : {16'h0, lo});
                chk("addr", out_addr, m_addr);
                chk("err", 32'(out_err), 32'(ev && ee));
                chk("busy", 32'(busy), 32'(m_data.size() >= DEPTH - 1));
                if (clear) begin
                    m_data.delete(); m_err.delete();
                    m_addr = clear_addr & ~32'h1;
                end else begin
                    pops = (ev && out_ready) ? (off + halves) / 2 : 0;
                    if (ev && out_ready) begin
                        hs_addr.push_back(m_addr);
                        hs_data.push_back(is32 ? {hi, lo} : {16'h0, lo});
                        m_addr += 32'(2 * halves);
                    end
                    if (in_valid && (m_data.size() < DEPTH || pops > 0)) begin
                        m_data.push_back(in_rdata); m_err.push_back(in_err);
                    end
                    repeat (pops) begin void'(m_data.pop_front()); void'(m_err.pop_front()); end
                end
            end
        end
    end

    initial begin
        look();
        chk("t0_rst_addr", out_addr, 32'h0000_0080);
        @(posedge clk); #1; rst = 1'b0;
        // Aligned 32-bit then two compressed halves of one word
        hs_addr.delete(); hs_data.delete();
        drive(1, 32'h0000_0013, 0, 1);
        drive(1, 32'h4501_4501, 0, 1);
        repeat (4) drive(0, 0, 0, 1);
        chk("t1_count", 32'(hs_addr.size()), 32'd3);
        check_hs("t1_0", 0, 32'h80, 32'h0000_0013);
        check_hs("t1_1", 1, 32'h84, 32'h0000_4501);
        check_hs("t1_2", 2, 32'h86, 32'h0000_4501);
        // Unaligned 32-bit waits for its second word
        drive(0, 0, 0, 1, 1, 32'h0000_0103);
        hs_addr.delete(); hs_data.delete();
        drive(1, 32'h0013_4501, 0, 0);
        look();
        chk("t2_wait_valid", 32'(out_valid), 32'd0);
        drive(1, 32'h0000_0000, 0, 0);
        drive(0, 0, 0, 0);
        look();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_addr", out_addr, 32'h0000_0102);
        chk("t2_rdata", out_rdata, 32'h0000_0013);
        repeat (3) drive(0, 0, 0, 1);
        chk("t2_count", 32'(hs_addr.size()), 32'd2);
        check_hs("t2_0", 0, 32'h102, 32'h0000_0013);
        check_hs("t2_1", 1, 32'h106, 32'h0000_0000);
        // Error on the second half, then on a lone first half
        drive(0, 0, 0, 0, 1, 32'h0000_0202);
        drive(1, 32'h0003_0000, 0, 0);
        drive(1, 32'habcd_1234, 1, 0);
        drive(0, 0, 0, 0);
        look();
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_err", 32'(out_err), 32'd1);
        chk("t3_addr", out_addr, 32'h0000_0202);
        chk("t3_rdata", out_rdata, 32'h1234_0003);
        drive(0, 0, 0, 0, 1, 32'h0000_0302);
        drive(1, 32'h0003_0000, 1, 0);
        drive(0, 0, 0, 0);
        look();
        chk("t3b_valid", 32'(out_valid), 32'd1);
        chk("t3b_err", 32'(out_err), 32'd1);
        chk("t3b_addr", out_addr, 32'h0000_0302);
        // Fill to DEPTH; the fourth word is dropped
        drive(0, 0, 0, 0, 1, 32'h0000_0400);
        drive(1, 32'h0010_0013, 0, 0);
        drive(1, 32'h0020_0013, 0, 0);
        look();
        chk("t4_busy1", 32'(busy), 32'd0);
        drive(1, 32'h0030_0013, 0, 0);
        look();
        chk("t4_busy2", 32'(busy), 32'd1);
        drive(1, 32'hdead_beef, 0, 0);
        look();
        chk("t4_busy3", 32'(busy), 32'd1);
        drive(0, 0, 0, 0);
        look();
        chk("t4_rdata", out_rdata, 32'h0010_0013);
        hs_addr.delete(); hs_data.delete();
        repeat (5) drive(0, 0, 0, 1);
        chk("t4_count", 32'(hs_addr.size()), 32'd3);
        check_hs("t4_0", 0, 32'h400, 32'h0010_0013);
        check_hs("t4_1", 1, 32'h404, 32'h0020_0013);
        check_hs("t4_2", 2, 32'h408, 32'h0030_0013);
        // Clear wins over a push and a handshake in the same cycle
        drive(0, 0, 0, 0, 1, 32'h0000_0500);
        drive(1, 32'h0000_0013, 0, 0);
        drive(1, 32'h0000_0093, 0, 1, 1, 32'h0000_0602);
        hs_addr.delete(); hs_data.delete();
        drive(0, 0, 0, 1);
        look();
        chk("t5_addr", out_addr, 32'h0000_0602);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (2) drive(0, 0, 0, 1);
        chk("t5_count", 32'(hs_addr.size()), 32'd0);
        // Asynchronous reset mid-cycle
        drive(1, 32'h0000_0013, 0, 0);
        drive(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_addr", out_addr, 32'h0000_0080);
        chk("t6_busy", 32'(busy), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        // Arrival-cycle visibility
        drive(1, 32'h0000_0013, 0, 1);
        look();
`ifdef INSTR_FIFO_BYPASS_EN
        chk("t7_same_valid", 32'(out_valid), 32'd1);
        chk("t7_same_rdata", out_rdata, 32'h0000_0013);
`else
        chk("t7_same_valid", 32'(out_valid), 32'd0);
`endif
        drive(0, 0, 0, 1);
        look();
`ifdef INSTR_FIFO_BYPASS_EN
        chk("t7_next_valid", 32'(out_valid), 32'd0);
`else
        chk("t7_next_valid", 32'(out_valid), 32'd1);
        chk("t7_next_rdata", out_rdata, 32'h0000_0013);
`endif
        drive(0, 0, 0, 1);
        look();
        chk("t7_addr", out_addr, 32'h0000_0084);
        // Mixed stream with a stalling consumer, fetch held off while busy
        drive(0, 0, 0, 0, 1, 32'h0000_1000);
        foreach (tbl[i]) begin
            for (int t = 0; t < 10; t++) begin
                @(posedge clk); #1;
                out_ready = (cyc % 3) != 0; cyc++;
                clear = 1'b0; in_err = 1'b0; in_rdata = tbl[i]; in_valid = !busy;
                if (in_valid) break;
            end
        end
        repeat (12) drive(0, 0, 0, 1);
        look();
        chk("t8_drained", 32'(out_valid), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
